// File: rtl/logcap_cmd_master.sv
// logcap_cmd_master: host-side command master for the logic-capture core.
// Queues {opcode, payload, burst} requests, drives command/commandStrobe,
// waits for the status ack, captures regOut, completes the CMD_ACK handshake
// and returns one response per burst iteration. An ack that never arrives
// (or never clears) ends the request with an ABORT command and an error response.
module logcap_cmd_master #(
    parameter int NUM_REGS    = 8,
    parameter int QDEPTH      = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int ACK_BIT     = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_cmd,
    input  logic [NUM_REGS*8-1:0] req_payload,
    input  logic [CNT_W-1:0]      req_burst,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NUM_REGS*8-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_last,
    output logic [7:0]            command,
    output logic                  commandStrobe,
    output logic [NUM_REGS*8-1:0] regIn,
    input  logic [NUM_REGS*8-1:0] regOut,
    input  logic [7:0]            status,
    output logic                  busy
);
    localparam int PW = NUM_REGS * 8;
    localparam int AW = $clog2(QDEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0]    T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]    T_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_ABORT = 8'h02;
    localparam logic [7:0] CMD_ACK   = 8'h08;

    typedef enum logic [3:0] {
        IDLE, LOAD, ARM, STROBE, WAIT_ACK, CAPTURE, ACK_STROBE, WAIT_CLR, RSP, ABORT
    } state_t;

    // Request queue storage (data only, never reset)
    logic [7:0]       cmd_mem_q   [QDEPTH];
    logic [PW-1:0]    pay_mem_q   [QDEPTH];
    logic [CNT_W-1:0] burst_mem_q [QDEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        q_empty, q_full, push, pop;
    logic [7:0]       head_cmd;
    logic [PW-1:0]    head_payload;
    logic [CNT_W-1:0] head_burst;

    state_t           state_q, state_d;
    logic [7:0]       command_q, command_d, orig_cmd_q, orig_cmd_d;
    logic             strobe_q, strobe_d;
    logic [PW-1:0]    regin_q, regin_d, rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             ack;
    logic             unused_status;

    assign ack           = status[ACK_BIT];
    assign unused_status = ^status;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_cmd     = cmd_mem_q[rd_ptr_q[AW-1:0]];
    assign head_payload = pay_mem_q[rd_ptr_q[AW-1:0]];
    assign head_burst   = burst_mem_q[rd_ptr_q[AW-1:0]];

    assign req_ready     = !q_full;
    assign rsp_valid     = (state_q == RSP);
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_last      = rsp_last_q;
    assign command       = command_q;
    assign commandStrobe = strobe_q;
    assign regIn         = regin_q;
    assign busy          = (state_q != IDLE) || !q_empty;

    // Queue pointer update; pop happens in LOAD, which consumes the head entry
    always_comb begin
        push     = req_valid && !q_full;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Queue entry write
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q[AW-1:0]]   <= req_cmd;
            pay_mem_q[wr_ptr_q[AW-1:0]]   <= req_payload;
            burst_mem_q[wr_ptr_q[AW-1:0]] <= req_burst;
        end
    end

    // Sequencer next-state; bus outputs are registered so the strobe and its
    // command appear together in the cycle the FSM sits in a strobe state
    always_comb begin
        state_d     = state_q;
        command_d   = command_q;
        orig_cmd_d  = orig_cmd_q;
        strobe_d    = 1'b0;
        regin_d     = regin_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        remaining_d = remaining_q;
        tmo_cnt_d   = tmo_cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A push in this cycle is already in memory when LOAD reads it
                if (!q_empty || push) state_d = LOAD;
            end
            LOAD: begin
                pop         = 1'b1;
                regin_d     = head_payload;
                command_d   = head_cmd;
                orig_cmd_d  = head_cmd;
                rsp_err_d   = 1'b0;
                remaining_d = (head_burst == '0) ? ONE : head_burst;
                if (head_cmd == CMD_NOP) begin
                    // NOP never touches the bus and always completes in one response
                    remaining_d = ONE;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    state_d     = RSP;
                end else begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!ack) begin
                    strobe_d  = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                tmo_cnt_d = tmo_cnt_q + T_ONE;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                tmo_cnt_d = tmo_cnt_q + T_ONE;
                if (ack) begin
                    state_d = CAPTURE;
                end else if (tmo_cnt_q == T_LAST) begin
                    command_d = CMD_ABORT;
                    strobe_d  = 1'b1;
                    state_d   = ABORT;
                end
            end
            CAPTURE: begin
                rsp_data_d = regOut;
                command_d  = CMD_ACK;
                strobe_d   = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = ACK_STROBE;
            end
            ACK_STROBE: begin
                tmo_cnt_d = tmo_cnt_q + T_ONE;
                state_d   = WAIT_CLR;
            end
            WAIT_CLR: begin
                tmo_cnt_d = tmo_cnt_q + T_ONE;
                if (!ack) begin
                    rsp_last_d = (remaining_q == ONE);
                    state_d    = RSP;
                end else if (tmo_cnt_q == T_LAST) begin
                    command_d = CMD_ABORT;
                    strobe_d  = 1'b1;
                    state_d   = ABORT;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (remaining_q > ONE) begin
                        remaining_d = remaining_q - ONE;
                        command_d   = orig_cmd_q;
                        state_d     = ARM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ABORT: begin
                rsp_err_d   = 1'b1;
                rsp_last_d  = 1'b1;
                rsp_data_d  = '0;
                remaining_d = ONE;
                state_d     = RSP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops everything with no ABORT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            command_q   <= 8'h00;
            orig_cmd_q  <= 8'h00;
            strobe_q    <= 1'b0;
            regin_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            remaining_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            command_q   <= command_d;
            orig_cmd_q  <= orig_cmd_d;
            strobe_q    <= strobe_d;
            regin_q     <= regin_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            remaining_q <= remaining_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_logcap_cmd_master.sv
// Testbench for logcap_cmd_master: behavioural core responder, strobe and
// response monitors, a table of single-request vectors and directed sequences.
module tb_logcap_cmd_master;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [63:0] req_payload = 64'h0;
    logic [15:0] req_burst = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic [7:0]  command;
    logic        commandStrobe;
    logic [63:0] regIn;
    logic [63:0] regOut = 64'h0;
    logic [7:0]  status;
    logic        busy;

    logcap_cmd_master #(
        .NUM_REGS(8), .QDEPTH(4), .ACK_TIMEOUT(16), .ACK_BIT(3), .CNT_W(16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_payload(req_payload), .req_burst(req_burst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .command(command), .commandStrobe(commandStrobe),
        .regIn(regIn), .regOut(regOut), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core responder controls (written only by the stimulus process)
    logic        core_en = 1'b1;
    logic        ack_force = 1'b0;
    int          ack_delay = 3;
    int          ro_base = 0;
    logic [63:0] ro_tab [8];

    // Core responder: acks a command after ack_delay clocks, drops ack on CMD_ACK
    logic ack_core = 1'b0;
    logic arming = 1'b0;
    logic ack;
    int   dly = 0;
    int   ncmd = 0;
    int   ro_idx = 0;
    assign ack    = ack_core | ack_force;
    assign status = {4'b0000, ack, 3'b000};
    always @(posedge clk) begin
        if (!resetn) begin
            ack_core <= 1'b0;
            arming   <= 1'b0;
        end else if (commandStrobe && command == 8'h08) begin
            ack_core <= 1'b0;
        end else if (commandStrobe && command != 8'h02) begin
            ncmd <= ncmd + 1;
            if (core_en) begin
                arming <= 1'b1;
                dly    <= ack_delay;
                ro_idx <= ncmd - ro_base;
            end
        end else if (arming) begin
            if (dly <= 1) begin
                ack_core <= 1'b1;
                arming   <= 1'b0;
                regOut   <= ro_tab[ro_idx[2:0]];
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Strobe and response monitors
    logic [7:0]  str_cmd [256];
    logic [63:0] str_reg [256];
    int          str_cyc [256];
    logic [63:0] rsp_d_arr [256];
    logic        rsp_e_arr [256];
    logic        rsp_l_arr [256];
    int   nstr = 0;
    int   nrsp = 0;
    int   viol = 0;
    int   ack_rise_cyc = 0;
    logic prev_strobe = 1'b0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (commandStrobe) begin
            str_cmd[nstr[7:0]] <= command;
            str_reg[nstr[7:0]] <= regIn;
            str_cyc[nstr[7:0]] <= cyc;
            nstr <= nstr + 1;
            if (prev_strobe || rsp_valid) viol <= viol + 1;
        end
        prev_strobe <= commandStrobe;
        if (ack && !prev_ack) ack_rise_cyc <= cyc;
        prev_ack <= ack;
        if (rsp_valid && rsp_ready) begin
            rsp_d_arr[nrsp[7:0]] <= rsp_data;
            rsp_e_arr[nrsp[7:0]] <= rsp_err;
            rsp_l_arr[nrsp[7:0]] <= rsp_last;
            nrsp <= nrsp + 1;
        end
    end

    function automatic logic [7:0] ix(input int i);
        return i[7:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name, input int target, input int budget);
        int k = 0;
        while (nrsp < target && k < budget) begin
            @(posedge clk); #1; k++;
        end
        check_int(name, (nrsp >= target) ? 1 : 0, 1);
    endtask

    task automatic push_req(input logic [7:0] c, input logic [63:0] p, input logic [15:0] b);
        req_valid   = 1'b1;
        req_cmd     = c;
        req_payload = p;
        req_burst   = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] pay;
        logic [15:0] burst;
        int          dly;
        logic [63:0] ro;
        int          exp_str;
        logic [63:0] exp_data;
    } vec_t;
    vec_t vec [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sb, rb, pc, s0;
        logic [63:0] d0;
        logic [5:0] acc;
        logic [5:0] exp_acc;

        vec[0] = '{8'h04, 64'h00000014_0000006E, 16'd1, 5, 64'hA5A5_5A5A_0123_4567, 2, 64'hA5A5_5A5A_0123_4567};
        vec[1] = '{8'h00, 64'h0000_0000_0000_DEAD, 16'd3, 2, 64'h1111_1111_1111_1111, 0, 64'h0};
        vec[2] = '{8'h10, 64'h0123_4567_89AB_CDEF, 16'd0, 1, 64'hCAFE_F00D_1234_5678, 2, 64'hCAFE_F00D_1234_5678};
        vec[3] = '{8'h05, 64'h0, 16'd1, 3, 64'hFFFF_FFFF_0000_0000, 2, 64'hFFFF_FFFF_0000_0000};
        for (int k = 0; k < 8; k++) ro_tab[k] = 64'h0;

        // Reset values
        wait_cycles(3);
        check("rst_command", 64'(command), 64'h00);
        check("rst_strobe", 64'(commandStrobe), 64'h0);
        check("rst_regin", regIn, 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_rsp_err_last", 64'({rsp_err, rsp_last}), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        resetn = 1'b1;
        wait_cycles(2);

        // Table of single requests
        for (int i = 0; i < 4; i++) begin
            ro_tab[0] = vec[i].ro;
            ro_base   = ncmd;
            ack_delay = vec[i].dly;
            sb = nstr; rb = nrsp; pc = cyc;
            push_req(vec[i].cmd, vec[i].pay, vec[i].burst);
            wait_rsp($sformatf("v%0d_rsp_arrives", i), rb + 1, 200);
            wait_cycles(4);
            check_int($sformatf("v%0d_nstrobe", i), nstr - sb, vec[i].exp_str);
            check_int($sformatf("v%0d_nrsp", i), nrsp - rb, 1);
            check($sformatf("v%0d_rsp_data", i), rsp_d_arr[ix(rb)], vec[i].exp_data);
            check($sformatf("v%0d_rsp_err", i), 64'(rsp_e_arr[ix(rb)]), 64'h0);
            check($sformatf("v%0d_rsp_last", i), 64'(rsp_l_arr[ix(rb)]), 64'h1);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'h0);
            if (vec[i].exp_str == 2) begin
                check($sformatf("v%0d_cmd", i), 64'(str_cmd[ix(sb)]), 64'(vec[i].cmd));
                check($sformatf("v%0d_regin", i), str_reg[ix(sb)], vec[i].pay);
                check($sformatf("v%0d_ackcmd", i), 64'(str_cmd[ix(sb + 1)]), 64'h08);
                check_int($sformatf("v%0d_push_to_strobe", i), str_cyc[ix(sb)] - pc, 3);
                check_int($sformatf("v%0d_ack_to_strobe", i), str_cyc[ix(sb + 1)] - ack_rise_cyc, 2);
            end
        end

        // Burst of 4 reads
        ro_tab[0] = {8{8'h11}}; ro_tab[1] = {8{8'h22}};
        ro_tab[2] = {8{8'h33}}; ro_tab[3] = {8{8'h44}};
        ro_base = ncmd; ack_delay = 2;
        sb = nstr; rb = nrsp;
        push_req(8'h0B, 64'h0000_0000_0000_0400, 16'd4);
        wait_rsp("burst_rsp_arrive", rb + 4, 400);
        wait_cycles(4);
        check_int("burst_nrsp", nrsp - rb, 4);
        check_int("burst_nstrobe", nstr - sb, 8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("burst_data%0d", k), rsp_d_arr[ix(rb + k)], ro_tab[k]);
            check($sformatf("burst_last%0d", k), 64'(rsp_l_arr[ix(rb + k)]), (k == 3) ? 64'h1 : 64'h0);
            check($sformatf("burst_cmd%0d", k), 64'(str_cmd[ix(sb + 2 * k)]), 64'h0B);
            check($sformatf("burst_ack%0d", k), 64'(str_cmd[ix(sb + 2 * k + 1)]), 64'h08);
        end
        check("burst_regin_kept", str_reg[ix(sb + 6)], 64'h0000_0000_0000_0400);

        // Ack timeout with burst remainder dropped
        core_en = 1'b0;
        sb = nstr; rb = nrsp;
        push_req(8'h20, 64'h0000_0000_0000_0020, 16'd3);
        wait_rsp("tmo_rsp_arrive", rb + 1, 100);
        wait_cycles(8);
        check_int("tmo_nstrobe", nstr - sb, 2);
        check_int("tmo_nrsp", nrsp - rb, 1);
        check("tmo_first_cmd", 64'(str_cmd[ix(sb)]), 64'h20);
        check("tmo_abort_cmd", 64'(str_cmd[ix(sb + 1)]), 64'h02);
        check_int("tmo_abort_delay", str_cyc[ix(sb + 1)] - str_cyc[ix(sb)], 16);
        check("tmo_rsp_err", 64'(rsp_e_arr[ix(rb)]), 64'h1);
        check("tmo_rsp_last", 64'(rsp_l_arr[ix(rb)]), 64'h1);
        check("tmo_rsp_data", rsp_d_arr[ix(rb)], 64'h0);
        check("tmo_busy", 64'(busy), 64'h0);
        core_en = 1'b1;

        // Queue full while the FSM is stalled on rsp_ready, then drain in order
        for (int k = 0; k < 8; k++) ro_tab[k] = 64'hA0A0_A0A0_A0A0_A0A0 + 64'(k);
        ro_base = ncmd; ack_delay = 2;
        rsp_ready = 1'b0;
        sb = nstr; rb = nrsp;
        exp_acc = 6'b011111;
        for (int k = 0; k < 6; k++) begin
            req_valid   = 1'b1;
            req_cmd     = 8'h31 + 8'(k);
            req_payload = 64'(k) << 8;
            req_burst   = 16'd1;
            @(negedge clk);
            acc[k] = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++)
            check($sformatf("qfull_accept%0d", k), 64'(acc[k]), 64'(exp_acc[k]));
        begin
            int k = 0;
            while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
            check("stall_rsp_valid", 64'(rsp_valid), 64'h1);
        end
        s0 = nstr; d0 = rsp_data;
        wait_cycles(10);
        check_int("stall_no_strobe", nstr - s0, 0);
        check("stall_data_held", rsp_data, d0);
        check("stall_valid_held", 64'(rsp_valid), 64'h1);
        check("stall_ready_low", 64'(req_ready), 64'h0);
        rsp_ready = 1'b1;
        wait_rsp("qfull_drain", rb + 5, 600);
        wait_cycles(6);
        check_int("qfull_nrsp", nrsp - rb, 5);
        check_int("qfull_nstrobe", nstr - sb, 10);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("qfull_data%0d", k), rsp_d_arr[ix(rb + k)], ro_tab[k]);
            check($sformatf("qfull_cmd%0d", k), 64'(str_cmd[ix(sb + 2 * k)]), 64'(8'h31 + 8'(k)));
        end
        check("qfull_regin4", str_reg[ix(sb + 8)], 64'h0400);

        // Stale ack held high before the request
        ack_force = 1'b1;
        ro_tab[0] = 64'h5151_5151_5151_5151;
        ro_base = ncmd; sb = nstr; rb = nrsp;
        push_req(8'h40, 64'h0000_0000_0000_0040, 16'd1);
        wait_cycles(10);
        check_int("stale_no_strobe", nstr - sb, 0);
        check("stale_busy", 64'(busy), 64'h1);
        ack_force = 1'b0;
        pc = cyc;
        wait_rsp("stale_rsp_arrive", rb + 1, 100);
        wait_cycles(3);
        check_int("stale_arm_to_strobe", str_cyc[ix(sb)] - pc, 1);
        check("stale_cmd", 64'(str_cmd[ix(sb)]), 64'h40);
        check("stale_data", rsp_d_arr[ix(rb)], 64'h5151_5151_5151_5151);

        // Asynchronous reset in WAIT_ACK with a second request queued
        core_en = 1'b0;
        sb = nstr;
        push_req(8'h50, 64'h0000_0000_0000_0050, 16'd2);
        push_req(8'h51, 64'h0000_0000_0000_0051, 16'd1);
        begin
            int k = 0;
            while (nstr == sb && k < 50) begin @(posedge clk); #1; k++; end
            check_int("rst_mid_strobe_seen", nstr - sb, 1);
        end
        wait_cycles(3);
        #3;
        resetn = 1'b0;
        #1;
        check("rstm_command", 64'(command), 64'h00);
        check("rstm_strobe", 64'(commandStrobe), 64'h0);
        check("rstm_regin", regIn, 64'h0);
        check("rstm_rsp", 64'({rsp_valid, rsp_err, rsp_last}), 64'h0);
        check("rstm_rsp_data", rsp_data, 64'h0);
        check("rstm_busy", 64'(busy), 64'h0);
        check("rstm_req_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        resetn = 1'b1;
        core_en = 1'b1;
        s0 = nstr;
        wait_cycles(30);
        check_int("rstm_no_strobe_after", nstr - s0, 0);
        check("rstm_idle_after", 64'(busy), 64'h0);

        check_int("bus_protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
